// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered MDU results,
// plus MDU busy-bit scoreboard. Optional macro REGFILE_WB_BYPASS_EN cancels RS hazards on same-cycle head writes.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        PipeWrite_i,
  input  logic [4:0]  PipeRDaddr_i,
  input  logic [31:0] PipeRDdata_i,
  input  logic        MduValid_i,
  input  logic [4:0]  MduRDaddr_i,
  input  logic [31:0] MduRDdata_i,
  output logic        MduReady_o,
  input  logic        Issue_i,
  input  logic [4:0]  IssueRDaddr_i,
  input  logic [4:0]  RS1addr_i,
  input  logic [4:0]  RS2addr_i,
  input  logic [4:0]  RDaddr_i,
  output logic        Hazard_o,
  output logic        PipeHold_o,
  output logic        RegWrite_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] RDdata_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [36:0]   fifo_q [DEPTH];
  logic [36:0]   fifo_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   busy_q, busy_d;
  logic [3:0]    starve_q, starve_d;
  logic          hold_q, hold_d;

  logic          empty, full, push, pipe_win, head_pop;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;
  logic          rs1_hz, rs2_hz, rd_hz;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    head_addr = fifo_q[rd_ptr_q][36:32];
    head_data = fifo_q[rd_ptr_q][31:0];
    MduReady_o = !rst_i && !full;
    push      = MduValid_i && MduReady_o;
    pipe_win  = !rst_i && PipeWrite_i && (PipeRDaddr_i != 5'd0);
    head_pop  = !rst_i && !pipe_win && !empty;

    RegWrite_o = 1'b0;
    RDaddr_o   = 5'd0;
    RDdata_o   = 32'd0;
    if (pipe_win) begin
      RegWrite_o = 1'b1;
      RDaddr_o   = PipeRDaddr_i;
      RDdata_o   = PipeRDdata_i;
    end else if (head_pop) begin
      RegWrite_o = 1'b1;
      RDaddr_o   = head_addr;
      RDdata_o   = head_data;
    end else begin
      RegWrite_o = 1'b0;
    end

    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = {MduRDaddr_i, MduRDdata_i};
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = head_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(head_pop);

    // Set after clear so a same-cycle issue to the retiring address stays busy
    busy_d = busy_q;
    if (head_pop) busy_d[head_addr] = 1'b0;
    if (Issue_i && (IssueRDaddr_i != 5'd0)) busy_d[IssueRDaddr_i] = 1'b1;
    busy_d[0] = 1'b0;

    if (empty || head_pop) starve_d = 4'd0;
    else if (starve_q != 4'hF) starve_d = starve_q + 4'd1;
    else starve_d = starve_q;

    if (head_pop) hold_d = 1'b0;
    else if (starve_q == LIMIT) hold_d = 1'b1;
    else hold_d = hold_q;

    rs1_hz = (RS1addr_i != 5'd0) && busy_q[RS1addr_i];
    rs2_hz = (RS2addr_i != 5'd0) && busy_q[RS2addr_i];
    rd_hz  = (RDaddr_i  != 5'd0) && busy_q[RDaddr_i];
`ifdef REGFILE_WB_BYPASS_EN
    // The register file forwards this cycle's write data, so only source reads may skip the stall
    if (head_pop && (head_addr == RS1addr_i)) rs1_hz = 1'b0;
    if (head_pop && (head_addr == RS2addr_i)) rs2_hz = 1'b0;
`endif
    Hazard_o   = !rst_i && (rs1_hz || rs2_hz || rd_hz);
    PipeHold_o = hold_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= 32'd0;
      starve_q <= 4'd0;
      hold_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
    end
  end

  // Storage is only ever read behind a non-zero count, so it needs no reset
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: queue-based reference model, directed scenarios then random traffic.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int STARVE_LIMIT = 4;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pw, mv, mrdy, iss, hz, hold, rw;
  logic [4:0]  pa, ma, ia, rs1, rs2, rd, wa;
  logic [31:0] pd, md, wd;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .PipeWrite_i(pw), .PipeRDaddr_i(pa), .PipeRDdata_i(pd),
    .MduValid_i(mv), .MduRDaddr_i(ma), .MduRDdata_i(md), .MduReady_o(mrdy),
    .Issue_i(iss), .IssueRDaddr_i(ia),
    .RS1addr_i(rs1), .RS2addr_i(rs2), .RDaddr_i(rd),
    .Hazard_o(hz), .PipeHold_o(hold),
    .RegWrite_o(rw), .RDaddr_o(wa), .RDdata_o(wd)
  );

  int checks = 0;
  int failures = 0;
  logic [36:0] exp_q[$];
  logic [36:0] m_fifo[$];
  logic [31:0] m_busy = 32'd0;
  int          m_starve = 0;
  bit          m_hold = 1'b0;
  bit          acc = 1'b0;

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Write monitor: every register-file write must match the next scoreboard entry
  always @(negedge clk) begin
    if (rw === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected none", wa, wd);
      end else begin
        check("write", {wa, wd}, exp_q.pop_front());
      end
    end
  end

  // One clock: predict this cycle's outputs, check at negedge, then advance the model
  task automatic step();
    bit win, pop, e_ready, e_rw, e_hz;
    logic [36:0] head;
    int n;
    n = m_fifo.size();
    head = (n > 0) ? m_fifo[0] : 37'd0;
    e_ready = !rst && (n < DEPTH);
    win = !rst && pw && (pa != 5'd0);
    pop = !rst && !win && (n > 0);
    e_rw = win || pop;
    if (win) exp_q.push_back({pa, pd});
    else if (pop) exp_q.push_back(head);
    e_hz = 1'b0;
    if (!rst) begin
      if (rs1 != 5'd0 && m_busy[rs1] && !(BYP && pop && head[36:32] == rs1)) e_hz = 1'b1;
      if (rs2 != 5'd0 && m_busy[rs2] && !(BYP && pop && head[36:32] == rs2)) e_hz = 1'b1;
      if (rd != 5'd0 && m_busy[rd]) e_hz = 1'b1;
    end
    acc = mv && e_ready;
    @(negedge clk);
    check("MduReady_o", {36'd0, mrdy}, {36'd0, e_ready});
    check("Hazard_o", {36'd0, hz}, {36'd0, e_hz});
    check("PipeHold_o", {36'd0, hold}, {36'd0, m_hold});
    check("RegWrite_o", {36'd0, rw}, {36'd0, e_rw});
    if (!e_rw) check("idle_bus", {wa, wd}, 37'd0);
    @(posedge clk);
    if (rst) begin
      m_fifo.delete();
      m_busy = 32'd0;
      m_starve = 0;
      m_hold = 1'b0;
    end else begin
      if (pop) m_hold = 1'b0;
      else if (m_starve == STARVE_LIMIT) m_hold = 1'b1;
      if (n == 0 || pop) m_starve = 0;
      else if (m_starve < 15) m_starve++;
      if (pop) begin
        void'(m_fifo.pop_front());
        m_busy[head[36:32]] = 1'b0;
      end
      if (iss && ia != 5'd0) m_busy[ia] = 1'b1;
      if (acc) m_fifo.push_back({ma, md});
    end
    #1;
  endtask

  initial begin
    logic [36:0] res [3];
    int idx;
    {pw, pa, pd, mv, ma, md, iss, ia, rs1, rs2, rd} = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    repeat (3) step();

    // Long-latency result to x5 with decode reading x5
    iss = 1'b1; ia = 5'd5; step();
    iss = 1'b0; rs1 = 5'd5;
    repeat (10) step();
    mv = 1'b1; ma = 5'd5; md = 32'hDEADBEEF; step();
    mv = 1'b0;
    repeat (3) step();
    rs1 = 5'd0;

    // Starvation behind continuous pipe writes to x7
    pw = 1'b1; pa = 5'd7; pd = 32'h0000_0777;
    mv = 1'b1; ma = 5'd9; md = 32'h0909_0909; step();
    mv = 1'b0;
    for (int c = 0; c < 10; c++) begin pw = !m_hold; pd = $urandom; step(); end
    pw = 1'b0;

    // Fill the FIFO under pipe traffic; third result held off until a pop
    res[0] = {5'd10, 32'h1111_1111};
    res[1] = {5'd11, 32'h2222_2222};
    res[2] = {5'd12, 32'h3333_3333};
    idx = 0;
    pa = 5'd7;
    for (int c = 0; c < 14; c++) begin
      mv = (idx < 3);
      {ma, md} = (idx < 3) ? res[idx] : 37'd0;
      pw = !m_hold;
      step();
      if (acc) idx++;
    end
    mv = 1'b0; pw = 1'b0;
    repeat (3) step();

    // Pipe write to x0 while the FIFO holds a result
    mv = 1'b1; ma = 5'd12; md = 32'hC0FF_EE00; step();
    mv = 1'b0; pw = 1'b1; pa = 5'd0; pd = 32'h5A5A_5A5A; step();
    pw = 1'b0; step();

    // Issue x3 in the cycle the head retires x3
    mv = 1'b1; ma = 5'd3; md = 32'h0000_0003; step();
    mv = 1'b0; iss = 1'b1; ia = 5'd3; step();
    iss = 1'b0; rs1 = 5'd3; step();

    // Reset with a result queued
    pw = 1'b1; pa = 5'd7; mv = 1'b1; ma = 5'd4; md = 32'h4444_4444; step();
    mv = 1'b0; step();
    rst = 1'b1; step();
    rst = 1'b0; pw = 1'b0; rd = 5'd4; step();
    rs1 = 5'd0; rd = 5'd0;

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      if (!mv || acc) begin
        mv = ($urandom_range(0, 2) == 0);
        ma = 5'($urandom_range(1, 31));
        md = $urandom;
      end
      pw  = !m_hold && ($urandom_range(0, 3) != 0);
      pa  = 5'($urandom_range(0, 31));
      pd  = $urandom;
      iss = ($urandom_range(0, 4) == 0);
      ia  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    {pw, mv, iss, rst} = '0;
    repeat (8) step();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected writes never appeared, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
